// File: rtl/contador_param.sv
// Parametrised up/down counter with load, programmable inclusive limit,
// wrap or saturate boundary handling, terminal-count pulse and sticky overflow.
module contador_param #(
    parameter int WIDTH = 12,
    parameter int STEP  = 1,
    parameter int MODE  = 0
) (
    input  logic             clck,
    input  logic             rst,
    input  logic             CLR,
    input  logic             LD,
    input  logic             EN,
    input  logic             UP,
    input  logic [WIDTH-1:0] INP,
    input  logic [WIDTH-1:0] LIM,
    output logic [WIDTH-1:0] OTP,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_load;
    logic             w_up_bound;
    logic             w_dn_bound;

    // The extra sum bit keeps a carry past the top of the range visible as a boundary.
    assign w_sum      = {1'b0, r_cnt} + STEP_W;
    assign w_diff     = r_cnt - STEP_W[WIDTH-1:0];
    assign w_load     = (INP > LIM) ? LIM : INP;
    assign w_up_bound = (w_sum > {1'b0, LIM});
    assign w_dn_bound = ({1'b0, r_cnt} < STEP_W);

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (CLR) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (LD) begin
            r_cnt <= w_load;
            r_tc  <= 1'b0;
        end else if (EN) begin
            if (UP) begin
                if (w_up_bound) begin
                    r_cnt <= (MODE == 0) ? '0 : LIM;
                    r_tc  <= 1'b1;
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= w_sum[WIDTH-1:0];
                    r_tc  <= 1'b0;
                end
            end else begin
                if (w_dn_bound) begin
                    r_cnt <= (MODE == 0) ? LIM : '0;
                    r_tc  <= 1'b1;
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= w_diff;
                    r_tc  <= 1'b0;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign OTP = r_cnt;
    assign TC  = r_tc;
    assign OVF = r_ovf;

endmodule

// File: tb/tb_contador_param.sv
// Directed self-checking bench: instance A (STEP=1, wrap) and instance B
// (STEP=3, saturate) share stimulus; each check looks at the relevant instance.
module tb_contador_param;

    logic        clck = 1'b0;
    logic        rst  = 1'b0;
    logic        CLR  = 1'b0;
    logic        LD   = 1'b0;
    logic        EN   = 1'b0;
    logic        UP   = 1'b1;
    logic [11:0] INP  = '0;
    logic [11:0] LIM  = 12'd4095;
    logic [11:0] otpA, otpB;
    logic        tcA, tcB, ovfA, ovfB;

    int checks   = 0;
    int failures = 0;

    contador_param #(.WIDTH(12), .STEP(1), .MODE(0)) dutA (
        .clck(clck), .rst(rst), .CLR(CLR), .LD(LD), .EN(EN), .UP(UP),
        .INP(INP), .LIM(LIM), .OTP(otpA), .TC(tcA), .OVF(ovfA)
    );

    contador_param #(.WIDTH(12), .STEP(3), .MODE(1)) dutB (
        .clck(clck), .rst(rst), .CLR(CLR), .LD(LD), .EN(EN), .UP(UP),
        .INP(INP), .LIM(LIM), .OTP(otpB), .TC(tcB), .OVF(ovfB)
    );

    always #5 clck = ~clck;

    task automatic applyStimulus(input logic clr, input logic ld, input logic en,
                                 input logic up, input logic [11:0] inp,
                                 input logic [11:0] lim);
        CLR = clr; LD = ld; EN = en; UP = up; INP = inp; LIM = lim;
        @(posedge clck);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        #3;
        checkOutput("reset_otp", otpA, 0);
        checkOutput("reset_tc", tcA, 0);
        checkOutput("reset_ovf", ovfA, 0);
        @(posedge clck); #1;
        rst = 1'b1;

        applyStimulus(0, 1, 1, 1, 12'd102, 12'd4095);
        checkOutput("ld_102", otpA, 102);
        applyStimulus(0, 1, 1, 1, 12'd23, 12'd4095);
        checkOutput("ld_23", otpA, 23);
        applyStimulus(0, 1, 1, 1, 12'd12, 12'd4095);
        checkOutput("ld_12", otpA, 12);
        for (int i = 13; i <= 15; i++) begin
            applyStimulus(0, 0, 1, 1, 12'd0, 12'd4095);
            checkOutput("cnt_up", otpA, i);
        end

        applyStimulus(0, 1, 0, 1, 12'd8, 12'd9);
        checkOutput("wrap_ld8", otpA, 8);
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd9);
        checkOutput("wrap_otp9", otpA, 9);
        checkOutput("wrap_tc_pre", tcA, 0);
        checkOutput("wrap_ovf_pre", ovfA, 0);
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd9);
        checkOutput("wrap_otp0", otpA, 0);
        checkOutput("wrap_tc", tcA, 1);
        checkOutput("wrap_ovf", ovfA, 1);
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd9);
        checkOutput("wrap_otp1", otpA, 1);
        checkOutput("wrap_tc_post", tcA, 0);
        checkOutput("wrap_ovf_sticky", ovfA, 1);
        applyStimulus(1, 1, 1, 1, 12'd5, 12'd9);
        checkOutput("clr_otp", otpA, 0);
        checkOutput("clr_ovf", ovfA, 0);
        checkOutput("clr_tc", tcA, 0);

        applyStimulus(0, 1, 0, 0, 12'd5, 12'd20);
        checkOutput("sat_ld5", otpB, 5);
        applyStimulus(0, 0, 1, 0, 12'd0, 12'd20);
        checkOutput("sat_otp2", otpB, 2);
        checkOutput("sat_tc_pre", tcB, 0);
        applyStimulus(0, 0, 1, 0, 12'd0, 12'd20);
        checkOutput("sat_otp0a", otpB, 0);
        checkOutput("sat_tc_a", tcB, 1);
        checkOutput("sat_ovf", ovfB, 1);
        applyStimulus(0, 0, 1, 0, 12'd0, 12'd20);
        checkOutput("sat_otp0b", otpB, 0);
        checkOutput("sat_tc_b", tcB, 1);
        applyStimulus(0, 0, 0, 0, 12'd0, 12'd20);
        checkOutput("sat_tc_idle", tcB, 0);
        checkOutput("sat_ovf_hold", ovfB, 1);

        applyStimulus(1, 0, 0, 1, 12'd0, 12'd50);
        applyStimulus(0, 1, 0, 1, 12'd80, 12'd50);
        checkOutput("clamp_ld", otpA, 50);
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd30);
        checkOutput("limdrop_otp", otpA, 0);
        checkOutput("limdrop_tc", tcA, 1);

        applyStimulus(1, 0, 0, 0, 12'd0, 12'd4095);
        applyStimulus(0, 0, 1, 0, 12'd0, 12'd4095);
        checkOutput("dwrap_otp", otpA, 4095);
        checkOutput("dwrap_tc", tcA, 1);
        applyStimulus(0, 0, 1, 0, 12'd0, 12'd4095);
        checkOutput("dwrap_otp2", otpA, 4094);
        checkOutput("dwrap_tc2", tcA, 0);

        applyStimulus(0, 1, 0, 1, 12'd7, 12'd0);
        checkOutput("lim0_ld", otpA, 0);
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd0);
        checkOutput("lim0_otp", otpA, 0);
        checkOutput("lim0_tc", tcA, 1);

        applyStimulus(0, 1, 0, 1, 12'd57, 12'd4095);
        checkOutput("mid_ld57", otpA, 57);
        checkOutput("mid_ovf_pre", ovfA, 1);
        LD = 1'b0; EN = 1'b1; UP = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_otp", otpA, 0);
        checkOutput("async_tc", tcA, 0);
        checkOutput("async_ovf", ovfA, 0);
        @(posedge clck); #1;
        checkOutput("hold_otp", otpA, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 1, 1, 12'd0, 12'd4095);
        checkOutput("post_rst_cnt", otpA, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
